// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the MIPS fetch-side control blocks.
//
// Contents:
//   seq_state_e          - next-PC sequencer state encoding
//   RESET_VECTOR_DEFAULT - PC value the core starts from after reset
//   PC_INC               - byte stride of a sequential fetch
//   is_aligned()         - word-alignment test on an address's low bits
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HOLD       = 2'd1,
        HOLD_REDIR = 2'd2
    } seq_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
    localparam int unsigned PC_INC               = 4;

    // Instructions are 32-bit words, so any target must have its two
    // least-significant bits at zero.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage : mips_pkg

// File: rtl/pc_redirect_sel.sv
// -----------------------------------------------------------------------------
// pc_redirect_sel
//
// Picks the winning control-flow redirect for this cycle and screens its target
// for word alignment. Purely combinational.
//
// Ports:
//   branch_taken, branch_target       - resolved taken branch
//   jump, jump_target                 - J/JAL
//   jump_reg, jump_reg_target         - JR/JALR
//   req_valid  (out)                  - a usable, aligned redirect exists
//   req_target (out)                  - target of the winning redirect
//   misalign   (out)                  - the winning redirect was misaligned
//                                       and has been dropped
// -----------------------------------------------------------------------------
module pc_redirect_sel
    import mips_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         jump_reg,
    input  logic [N-1:0] jump_reg_target,
    output logic         req_valid,
    output logic [N-1:0] req_target,
    output logic         misalign
);

    logic raw_valid;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block leaves a value unassigned and a latch
        // cannot be inferred.
        raw_valid  = 1'b0;
        req_target = branch_target;

        // Register-sourced jumps win over direct jumps, which win over branches.
        if (jump_reg) begin
            raw_valid  = 1'b1;
            req_target = jump_reg_target;
        end else if (jump) begin
            raw_valid  = 1'b1;
            req_target = jump_target;
        end else if (branch_taken) begin
            raw_valid  = 1'b1;
            req_target = branch_target;
        end

        // Only the winner is screened: a misaligned winner kills the request
        // outright rather than letting a lower-priority source through.
        misalign  = raw_valid && !is_aligned(req_target[1:0]);
        req_valid = raw_valid && !misalign;
    end

endmodule : pc_redirect_sel

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Next-PC controller sitting in front of the PC register. Chooses between
// sequential fetch and branch/jump/jump-register redirects, holds the PC while
// the pipeline is stalled, parks a redirect that arrives during a stall and
// applies it on the first un-stalled cycle, and flags misaligned targets.
//
// Parameters:
//   N            - address width
//   RESET_VECTOR - PC after reset; must match the PC register's reset value
//
// Ports:
//   clk                         - rising-edge clock
//   reset                       - asynchronous, active-low reset
//   PCValue                     - current PC from the PC register
//   Stall                       - hazard unit requests PC hold
//   BranchTaken, BranchTarget   - resolved taken branch and its destination
//   Jump, JumpTarget            - J/JAL and its destination
//   JumpReg, JumpRegTarget      - JR/JALR and its destination
//   NewPC        (out, comb)    - next PC to the PC register
//   PCWrite      (out, comb)    - PC register write enable
//   FlushIF      (out, comb)    - squash the instruction in IF/ID
//   RedirPending (out, reg)     - a parked redirect exists
//   MisalignErr  (out, reg)     - sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(RESET_VECTOR_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] PCValue,
    input  logic         Stall,
    input  logic         BranchTaken,
    input  logic [N-1:0] BranchTarget,
    input  logic         Jump,
    input  logic [N-1:0] JumpTarget,
    input  logic         JumpReg,
    input  logic [N-1:0] JumpRegTarget,
    output logic [N-1:0] NewPC,
    output logic         PCWrite,
    output logic         FlushIF,
    output logic         RedirPending,
    output logic         MisalignErr
);

    seq_state_e   state;
    seq_state_e   next_state;
    logic [N-1:0] pending;
    logic [N-1:0] pending_next;
    logic         req_valid;
    logic [N-1:0] req_target;
    logic         misalign;
    logic [N-1:0] seq_pc;

    pc_redirect_sel #(
        .N (N)
    ) u_redirect_sel (
        .branch_taken    (BranchTaken),
        .branch_target   (BranchTarget),
        .jump            (Jump),
        .jump_target     (JumpTarget),
        .jump_reg        (JumpReg),
        .jump_reg_target (JumpRegTarget),
        .req_valid       (req_valid),
        .req_target      (req_target),
        .misalign        (misalign)
    );

    // Sequential successor; wraps silently at the top of the address space.
    assign seq_pc = PCValue + N'(PC_INC);

    // -------------------------------------------------------------------------
    // State, pending target and error flag
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the pending target is a single register, not a memory, so
            // it is cleared on reset; this guarantees a redirect parked before
            // reset can never resurface afterwards.
            state       <= RUN;
            pending     <= '0;
            MisalignErr <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= pending_next;
            if (misalign) begin
                MisalignErr <= 1'b1;
            end
        end
    end

    // The parked-redirect flag is a decode of the state register, so it is as
    // registered as the state itself and clears with it on reset.
    assign RedirPending = (state == HOLD_REDIR);

    // -------------------------------------------------------------------------
    // Next-state and next-PC selection
    // -------------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        pending_next = pending;
        NewPC        = seq_pc;
        PCWrite      = 1'b0;
        FlushIF      = 1'b0;

        if (!reset) begin
            // Present the reset vector while reset is held so the PC register
            // sees a consistent value; writes are suppressed.
            NewPC = RESET_VECTOR;
        end else begin
            case (state)
                // HOLD without a stall behaves exactly like RUN, so the two
                // states share their decode and differ only in where they came
                // from.
                RUN, HOLD: begin
                    if (Stall) begin
                        NewPC = PCValue;
                        if (req_valid) begin
                            pending_next = req_target;
                            next_state   = HOLD_REDIR;
                        end else begin
                            next_state   = HOLD;
                        end
                    end else begin
                        PCWrite    = 1'b1;
                        next_state = RUN;
                        if (req_valid) begin
                            NewPC   = req_target;
                            FlushIF = 1'b1;
                        end
                    end
                end

                HOLD_REDIR: begin
                    if (Stall) begin
                        NewPC = PCValue;
                        // Latest redirect wins while still parked.
                        if (req_valid) begin
                            pending_next = req_target;
                        end
                    end else begin
                        // Release: a redirect arriving in the release cycle is
                        // younger than the parked one and supersedes it.
                        PCWrite      = 1'b1;
                        FlushIF      = 1'b1;
                        NewPC        = req_valid ? req_target : pending;
                        pending_next = '0;
                        next_state   = RUN;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to RUN without writing.
                    pending_next = '0;
                    next_state   = RUN;
                end
            endcase
        end
    end

endmodule : pc_sequencer
